row_feeder: RTL and testbench
=============================

ROW_FEEDER -- requirements
Module: row_feeder

Interface
REQ-001 Parameters: DATA_WIDTH_8, default 8, pixel width.
REQ-002 Parameters: ADDR_WIDTH, default 10, column/row counter width.
REQ-003 Parameters: FRAME_WIDTH, default 320, pixels per row.
REQ-004 Parameters: FRAME_HEIGHT, default 240, rows per frame.
REQ-005 Parameters: INTEGRAL_WIDTH, default 3, window size of downstream row chain.
REQ-006 clk_os  in  1  single clock; all logic on rising edge.
REQ-007 reset_os  in  1  asynchronous, active-high reset.
REQ-008 i_frame_start  in  1  one-cycle pulse requesting a new frame.
REQ-009 i_pix_valid  in  1  source pixel valid.
REQ-010 i_pix_data  in  DATA_WIDTH_8  source pixel.
REQ-011 o_pix_ready  out  1  feeder accepts pixel this cycle.
REQ-012 o_wen  out  1  write enable to row chain.
REQ-013 o_fifo_in  out  DATA_WIDTH_8  pixel to row chain.
REQ-014 o_col  out  ADDR_WIDTH  column of pixel on o_fifo_in.
REQ-015 o_row  out  ADDR_WIDTH  row of pixel on o_fifo_in.
REQ-016 o_window_valid  out  1  written pixel completes a full INTEGRAL_WIDTH x INTEGRAL_WIDTH window.
REQ-017 o_busy  out  1  high in any state except IDLE.
REQ-018 o_frame_done  out  1  one-cycle pulse at frame completion.

Function
REQ-019 FSM states IDLE, STREAM, FLUSH, DONE; IDLE->STREAM on i_frame_start; STREAM->FLUSH (macro on) or DONE (macro off) after last pixel accepted; FLUSH->DONE after flush count; DONE->IDLE unconditionally next cycle.
REQ-020 o_pix_ready = 1 only in STREAM, combinationally from state, independent of i_pix_valid.
REQ-021 Transfer occurs when i_pix_valid & o_pix_ready; no transfer when either low, counters hold.
REQ-022 Latency 1: transfer at cycle N -> o_wen=1, o_fifo_in=pixel, o_col/o_row=its coordinates at N+1; o_wen=0 otherwise (except FLUSH).
REQ-023 Column counter increments per transfer; wraps FRAME_WIDTH-1 -> 0 and increments row counter.
REQ-024 Last pixel = row FRAME_HEIGHT-1, col FRAME_WIDTH-1; its transfer triggers leaving STREAM; counters clear to 0.
REQ-025 o_window_valid = o_wen & (o_row >= INTEGRAL_WIDTH-1) & (o_col >= INTEGRAL_WIDTH-1), registered with o_wen; always 0 in FLUSH.
REQ-026 o_frame_done = 1 exactly for the cycle spent in DONE.
REQ-027 i_frame_start outside IDLE ignored; i_frame_start in DONE ignored (no back-to-back restart).
REQ-028 o_fifo_in holds last written value when o_wen=0.
REQ-029 Arithmetic unsigned; counters sized ADDR_WIDTH; FRAME_WIDTH, FRAME_HEIGHT must be <= 2^ADDR_WIDTH.

Reset
REQ-030 reset_os asserted: state IDLE, counters 0, o_wen 0, o_fifo_in 0, o_col 0, o_row 0, o_window_valid 0, o_busy 0, o_frame_done 0, o_pix_ready 0.
REQ-031 Reset mid-frame aborts immediately; no o_frame_done pulse; next frame restarts at row 0 col 0.

Configuration
REQ-032 Macro ROW_FEEDER_FLUSH_EN defined: FLUSH state emits FRAME_WIDTH consecutive cycles of o_wen=1, o_fifo_in=0, o_col 0..FRAME_WIDTH-1, o_row=FRAME_HEIGHT, o_pix_ready=0, then DONE.
REQ-033 Macro undefined: FLUSH state absent; STREAM->DONE directly; o_frame_done the cycle after last pixel write.

Verification (FRAME_WIDTH=4, FRAME_HEIGHT=3, INTEGRAL_WIDTH=3)
REQ-034 Reset then frame_start, 12 pixels 1..12 continuously valid -> o_wen 12 cycles, o_fifo_in 1..12, o_col 0..3 repeating, o_row 0,0,0,0,1..2; o_frame_done one cycle.
REQ-035 Same stream -> o_window_valid high only for pixels 11,12 (row 2, col 2,3).
REQ-036 i_pix_valid toggled 1,0,1,0 -> o_wen only after valid cycles, counters hold during gaps, data unchanged.
REQ-037 frame_start pulsed at pixel 5 mid-frame -> ignored, frame completes normally with 12 writes.
REQ-038 reset_os at pixel 6 -> all outputs 0 immediately, no frame_done; new frame starts at col 0 row 0.
REQ-039 ROW_FEEDER_FLUSH_EN defined -> after pixel 12, 4 writes of 0 with o_row=3, o_pix_ready=0, then o_frame_done.

Source files
------------

// File: rtl/row_feeder_if.sv
// Pixel-source and row-chain signals of row_feeder, bundled as one interface.
// master = pixel source / frame controller side, slave = the feeder itself.
interface row_feeder_if #(
    parameter int DATA_WIDTH_8 = 8,
    parameter int ADDR_WIDTH   = 10
);
    logic                    i_frame_start;
    logic                    i_pix_valid;
    logic [DATA_WIDTH_8-1:0] i_pix_data;
    logic                    o_pix_ready;
    logic                    o_wen;
    logic [DATA_WIDTH_8-1:0] o_fifo_in;
    logic [ADDR_WIDTH-1:0]   o_col;
    logic [ADDR_WIDTH-1:0]   o_row;
    logic                    o_window_valid;
    logic                    o_busy;
    logic                    o_frame_done;

    modport master (
        output i_frame_start, i_pix_valid, i_pix_data,
        input  o_pix_ready, o_wen, o_fifo_in, o_col, o_row,
               o_window_valid, o_busy, o_frame_done
    );

    modport slave (
        input  i_frame_start, i_pix_valid, i_pix_data,
        output o_pix_ready, o_wen, o_fifo_in, o_col, o_row,
               o_window_valid, o_busy, o_frame_done
    );
endinterface

// File: rtl/row_feeder.sv
// Streams one FRAME_WIDTH x FRAME_HEIGHT frame of pixels into a row chain with coordinates.
// Optional macro ROW_FEEDER_FLUSH_EN appends one row of zero pixels after the frame.
module row_feeder #(
    parameter int DATA_WIDTH_8   = 8,
    parameter int ADDR_WIDTH     = 10,
    parameter int FRAME_WIDTH    = 320,
    parameter int FRAME_HEIGHT   = 240,
    parameter int INTEGRAL_WIDTH = 3
) (
    input logic         clk_os,
    input logic         reset_os,
    row_feeder_if.slave bus
);

    localparam logic [ADDR_WIDTH-1:0] LAST_COL  = ADDR_WIDTH'(FRAME_WIDTH - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ROW  = ADDR_WIDTH'(FRAME_HEIGHT - 1);
    localparam logic [ADDR_WIDTH-1:0] WIN_EDGE  = ADDR_WIDTH'(INTEGRAL_WIDTH - 1);
`ifdef ROW_FEEDER_FLUSH_EN
    localparam logic [ADDR_WIDTH-1:0] FLUSH_ROW = ADDR_WIDTH'(FRAME_HEIGHT);
`endif

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FLUSH  = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   col_q, col_d;
    logic [ADDR_WIDTH-1:0]   row_q, row_d;
    logic                    wen_q, wen_d;
    logic [DATA_WIDTH_8-1:0] fifo_in_q, fifo_in_d;
    logic [ADDR_WIDTH-1:0]   out_col_q, out_col_d;
    logic [ADDR_WIDTH-1:0]   out_row_q, out_row_d;
    logic                    window_valid_q, window_valid_d;
    logic                    transfer;

    assign transfer = (state_q == STREAM) && bus.i_pix_valid;

    always_comb begin
        state_d        = state_q;
        col_d          = col_q;
        row_d          = row_q;
        wen_d          = 1'b0;
        fifo_in_d      = fifo_in_q;
        out_col_d      = out_col_q;
        out_row_d      = out_row_q;
        window_valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.i_frame_start) begin
                    state_d = STREAM;
                    col_d   = '0;
                    row_d   = '0;
                end
            end

            STREAM: begin
                if (transfer) begin
                    wen_d          = 1'b1;
                    fifo_in_d      = bus.i_pix_data;
                    out_col_d      = col_q;
                    out_row_d      = row_q;
                    window_valid_d = (row_q >= WIN_EDGE) && (col_q >= WIN_EDGE);
                    if (col_q == LAST_COL) begin
                        col_d = '0;
                        if (row_q == LAST_ROW) begin
                            row_d = '0;
`ifdef ROW_FEEDER_FLUSH_EN
                            state_d = FLUSH;
`else
                            state_d = DONE;
`endif
                        end else begin
                            row_d = row_q + 1'b1;
                        end
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end

`ifdef ROW_FEEDER_FLUSH_EN
            // Column counter is reused to walk the zero row below the frame.
            FLUSH: begin
                wen_d     = 1'b1;
                fifo_in_d = '0;
                out_col_d = col_q;
                out_row_d = FLUSH_ROW;
                if (col_q == LAST_COL) begin
                    col_d   = '0;
                    state_d = DONE;
                end else begin
                    col_d = col_q + 1'b1;
                end
            end
`endif

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_os or posedge reset_os) begin
        if (reset_os) begin
            state_q        <= IDLE;
            col_q          <= '0;
            row_q          <= '0;
            wen_q          <= 1'b0;
            fifo_in_q      <= '0;
            out_col_q      <= '0;
            out_row_q      <= '0;
            window_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            col_q          <= col_d;
            row_q          <= row_d;
            wen_q          <= wen_d;
            fifo_in_q      <= fifo_in_d;
            out_col_q      <= out_col_d;
            out_row_q      <= out_row_d;
            window_valid_q <= window_valid_d;
        end
    end

    assign bus.o_pix_ready    = (state_q == STREAM);
    assign bus.o_busy         = (state_q != IDLE);
    assign bus.o_frame_done   = (state_q == DONE);
    assign bus.o_wen          = wen_q;
    assign bus.o_fifo_in      = fifo_in_q;
    assign bus.o_col          = out_col_q;
    assign bus.o_row          = out_row_q;
    assign bus.o_window_valid = window_valid_q;

endmodule

// File: tb/tb_row_feeder.sv
// Scoreboard bench for row_feeder on a 4x3 frame with a 3x3 window.
// Define ROW_FEEDER_FLUSH_EN for both files to cover the trailing zero row.
module tb_row_feeder;
    localparam int DW = 8;
    localparam int AW = 10;
    localparam int FW = 4;
    localparam int FH = 3;
    localparam int IW = 3;

    localparam int M_IDLE   = 0;
    localparam int M_STREAM = 1;
    localparam int M_FLUSH  = 2;
    localparam int M_DONE   = 3;

    typedef struct {
        logic [DW-1:0] data;
        int            col;
        int            row;
        bit            wv;
    } exp_t;

    logic clk = 1'b0;
    logic reset_os;
    always #5 clk = ~clk;

    row_feeder_if #(.DATA_WIDTH_8(DW), .ADDR_WIDTH(AW)) bus ();

    row_feeder #(
        .DATA_WIDTH_8  (DW),
        .ADDR_WIDTH    (AW),
        .FRAME_WIDTH   (FW),
        .FRAME_HEIGHT  (FH),
        .INTEGRAL_WIDTH(IW)
    ) dut (
        .clk_os  (clk),
        .reset_os(reset_os),
        .bus     (bus)
    );

    exp_t          exp_q[$];
    int            total = 0;
    int            bad = 0;
    int            mode = M_IDLE;
    int            n_pix = 0;
    int            n_flush = 0;
    logic [DW-1:0] last_data = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    // Frame-level reference: pixel n of the frame sits at (n % FW, n / FW).
    task automatic model_step();
        exp_t e;
        if (reset_os) begin
            mode = M_IDLE;
            return;
        end
        case (mode)
            M_IDLE: if (bus.i_frame_start) begin
                mode  = M_STREAM;
                n_pix = 0;
            end
            M_STREAM: if (bus.i_pix_valid) begin
                e.data = bus.i_pix_data;
                e.col  = n_pix % FW;
                e.row  = n_pix / FW;
                e.wv   = (e.row >= IW - 1) && (e.col >= IW - 1);
                exp_q.push_back(e);
                n_pix++;
                if (n_pix == FW * FH) begin
`ifdef ROW_FEEDER_FLUSH_EN
                    mode    = M_FLUSH;
                    n_flush = 0;
`else
                    mode = M_DONE;
`endif
                end
            end
            M_FLUSH: begin
                e.data = '0;
                e.col  = n_flush;
                e.row  = FH;
                e.wv   = 1'b0;
                exp_q.push_back(e);
                n_flush++;
                if (n_flush == FW) mode = M_DONE;
            end
            default: mode = M_IDLE;
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic check_reset_outputs();
        chk("rst_wen", bus.o_wen, 0);
        chk("rst_fifo_in", bus.o_fifo_in, 0);
        chk("rst_col", bus.o_col, 0);
        chk("rst_row", bus.o_row, 0);
        chk("rst_window_valid", bus.o_window_valid, 0);
        chk("rst_busy", bus.o_busy, 0);
        chk("rst_frame_done", bus.o_frame_done, 0);
        chk("rst_pix_ready", bus.o_pix_ready, 0);
    endtask

    task automatic apply_reset();
        reset_os = 1'b1;
        #1;
        check_reset_outputs();
        exp_q.delete();
        mode      = M_IDLE;
        last_data = '0;
        @(posedge clk);
        #1;
        reset_os = 1'b0;
    endtask

    task automatic idle(input int cycles);
        bus.i_frame_start = 1'b0;
        bus.i_pix_valid   = 1'b0;
        repeat (cycles) tick();
    endtask

    // vmode: 0 continuous valid with data n+1, 1 alternating valid, 2 random valid.
    task automatic drive_frame(input int vmode, input int fs_at, input int rst_at, input bit fs_in_done);
        int cyc = 0;
        bus.i_frame_start = 1'b1;
        bus.i_pix_valid   = 1'b0;
        tick();
        bus.i_frame_start = 1'b0;
        while (mode != M_IDLE && cyc < 400) begin
            if (rst_at >= 0 && mode == M_STREAM && n_pix == rst_at) begin
                apply_reset();
                return;
            end
            case (vmode)
                0:       bus.i_pix_valid = 1'b1;
                1:       bus.i_pix_valid = (cyc % 2 == 0);
                default: bus.i_pix_valid = 1'($urandom_range(0, 1));
            endcase
            bus.i_pix_data    = (vmode == 0) ? DW'(n_pix + 1) : DW'($urandom);
            bus.i_frame_start = (fs_at >= 0 && mode == M_STREAM && n_pix == fs_at) ||
                                (fs_in_done && mode == M_DONE);
            tick();
            cyc++;
        end
        bus.i_frame_start = 1'b0;
        bus.i_pix_valid   = 1'b0;
        chk("frame_completes_busy", bus.o_busy, 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!reset_os) begin
            chk("pix_ready", bus.o_pix_ready, mode == M_STREAM);
            chk("busy", bus.o_busy, mode != M_IDLE);
            chk("frame_done", bus.o_frame_done, mode == M_DONE);
            if (bus.o_wen) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("fifo_in", bus.o_fifo_in, e.data);
                    chk("col", bus.o_col, e.col);
                    chk("row", bus.o_row, e.row);
                    chk("window_valid", bus.o_window_valid, e.wv);
                    last_data = e.data;
                end
            end else begin
                chk("window_valid_idle", bus.o_window_valid, 0);
                chk("fifo_in_hold", bus.o_fifo_in, last_data);
                if (exp_q.size() != 0) begin
                    chk("missing_write", 0, 1);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        reset_os          = 1'b1;
        bus.i_frame_start = 1'b0;
        bus.i_pix_valid   = 1'b0;
        bus.i_pix_data    = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs();
        reset_os = 1'b0;
        idle(2);

        drive_frame(0, -1, -1, 1'b0);
        idle(3);
        drive_frame(1, -1, -1, 1'b0);
        idle(2);
        drive_frame(0, 4, -1, 1'b1);
        idle(3);
        drive_frame(0, -1, 5, 1'b0);
        idle(2);
        drive_frame(0, -1, -1, 1'b0);
        for (int f = 0; f < 6; f++) begin
            idle($urandom_range(0, 3));
            drive_frame(2, (f == 2) ? 7 : -1, (f == 4) ? int'($urandom_range(1, 10)) : -1, f[0]);
        end
        idle(4);
        chk("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule
